ay_regs: RTL

- Register file and bus controller for the AY-3-891x core.
- Latches CPU address/data writes into the 16 PSG registers and presents them as decoded configuration buses to the tone, noise, mixer and envelope datapaths.
- Sequences the envelope generator: issues a restart pulse on every R13 write and divides the PSG clock into the tone (÷16) and envelope (÷256) tick strobes.
- Sits between the Z8S180 I/O decode and the ay_tone/ay_noise/ay_env/mixer blocks.

---
 rtl/ay_pkg.sv | 37 +++
 rtl/ay_prescaler.sv | 41 ++++
 rtl/ay_regs.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ay_pkg.sv
// Shared constants for the AY-3-891x register block: register indices,
// per-register write masks and envelope shape bit positions.
package ay_pkg;

  localparam logic [3:0] AY_R_TONE_A_LO = 4'd0;
  localparam logic [3:0] AY_R_TONE_A_HI = 4'd1;
  localparam logic [3:0] AY_R_TONE_B_LO = 4'd2;
  localparam logic [3:0] AY_R_TONE_B_HI = 4'd3;
  localparam logic [3:0] AY_R_TONE_C_LO = 4'd4;
  localparam logic [3:0] AY_R_TONE_C_HI = 4'd5;
  localparam logic [3:0] AY_R_NOISE     = 4'd6;
  localparam logic [3:0] AY_R_MIXER     = 4'd7;
  localparam logic [3:0] AY_R_AMP_A     = 4'd8;
  localparam logic [3:0] AY_R_AMP_B     = 4'd9;
  localparam logic [3:0] AY_R_AMP_C     = 4'd10;
  localparam logic [3:0] AY_R_ENV_LO    = 4'd11;
  localparam logic [3:0] AY_R_ENV_HI    = 4'd12;
  localparam logic [3:0] AY_R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] AY_R_IO_A      = 4'd14;
  localparam logic [3:0] AY_R_IO_B      = 4'd15;

  // Packed R15..R0, most significant byte is R15.
  localparam logic [127:0] AY_WR_MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  localparam int AY_ENV_CONT   = 3;
  localparam int AY_ENV_ATTACK = 2;
  localparam int AY_ENV_ALT    = 1;
  localparam int AY_ENV_HOLD   = 0;

  function automatic logic [7:0] ay_wr_mask(input logic [3:0] idx);
    return AY_WR_MASK[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ay_prescaler.sv
// Free-running PSG clock prescaler producing the /16 tone and /256 envelope
// tick strobes, each registered one cycle after the causing psg_clk_tick.
module ay_prescaler (
  input  logic clk,
  input  logic reset,
  input  logic psg_clk_tick,
  output logic tone_tick,
  output logic env_clk_tick
);

  logic [7:0] ctr_q, ctr_d;
  logic       tone_tick_q, tone_tick_d;
  logic       env_clk_tick_q, env_clk_tick_d;

  always_comb begin
    ctr_d          = ctr_q;
    tone_tick_d    = 1'b0;
    env_clk_tick_d = 1'b0;
    if (psg_clk_tick) begin
      ctr_d          = ctr_q + 8'd1;
      tone_tick_d    = (ctr_q[3:0] == 4'hF);
      env_clk_tick_d = (ctr_q == 8'hFF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q          <= 8'h00;
      tone_tick_q    <= 1'b0;
      env_clk_tick_q <= 1'b0;
    end else begin
      ctr_q          <= ctr_d;
      tone_tick_q    <= tone_tick_d;
      env_clk_tick_q <= env_clk_tick_d;
    end
  end

  assign tone_tick    = tone_tick_q;
  assign env_clk_tick = env_clk_tick_q;

endmodule

// File: rtl/ay_regs.sv
// AY-3-891x register file and bus controller. Define AY_REGS_IO_EN to make
// R14/R15 real I/O port registers; otherwise they read 0 and ignore writes.
module ay_regs
  import ay_pkg::*;
#(
  parameter logic [3:0] ADDR_HI = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psg_clk_tick,
  input  logic        latch,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        shape_tick,
  output logic        tone_tick,
  output logic        env_clk_tick,
  input  logic [7:0]  io_a_in,
  input  logic [7:0]  io_b_in,
  output logic [7:0]  io_a_out,
  output logic [7:0]  io_b_out
);

  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];
  logic [3:0] addr_q, addr_d;
  logic       sel_q, sel_d;
  logic [7:0] dout_q, dout_d;
  logic       shape_tick_q, shape_tick_d;
  logic       wr_allowed;
  logic [7:0] rd_val;

  always_comb begin
    rd_val     = regs_q[addr_q];
    wr_allowed = 1'b1;
`ifdef AY_REGS_IO_EN
    // Port pins are read back only while the port is configured as input.
    if (addr_q == AY_R_IO_A && !regs_q[AY_R_MIXER][6]) rd_val = io_a_in;
    if (addr_q == AY_R_IO_B && !regs_q[AY_R_MIXER][7]) rd_val = io_b_in;
`else
    if (addr_q == AY_R_IO_A || addr_q == AY_R_IO_B) begin
      rd_val     = 8'h00;
      wr_allowed = 1'b0;
    end
`endif
  end

  always_comb begin
    regs_d       = regs_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    dout_d       = dout_q;
    shape_tick_d = 1'b0;
    if (latch) begin
      addr_d = din[3:0];
      sel_d  = (din[7:4] == ADDR_HI);
    end else if (wr) begin
      if (sel_q && wr_allowed) begin
        regs_d[addr_q] = din & ay_wr_mask(addr_q);
        shape_tick_d   = (addr_q == AY_R_ENV_SHAPE);
      end
    end else if (rd) begin
      dout_d = sel_q ? rd_val : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      addr_q       <= 4'h0;
      sel_q        <= 1'b0;
      dout_q       <= 8'h00;
      shape_tick_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      shape_tick_q <= shape_tick_d;
    end
  end

  ay_prescaler u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .psg_clk_tick (psg_clk_tick),
    .tone_tick    (tone_tick),
    .env_clk_tick (env_clk_tick)
  );

  assign dout          = dout_q;
  assign shape_tick    = shape_tick_q;
  assign tone_period_a = {regs_q[AY_R_TONE_A_HI][3:0], regs_q[AY_R_TONE_A_LO]};
  assign tone_period_b = {regs_q[AY_R_TONE_B_HI][3:0], regs_q[AY_R_TONE_B_LO]};
  assign tone_period_c = {regs_q[AY_R_TONE_C_HI][3:0], regs_q[AY_R_TONE_C_LO]};
  assign noise_period  = regs_q[AY_R_NOISE][4:0];
  assign mixer         = regs_q[AY_R_MIXER];
  assign amp_a         = regs_q[AY_R_AMP_A][4:0];
  assign amp_b         = regs_q[AY_R_AMP_B][4:0];
  assign amp_c         = regs_q[AY_R_AMP_C][4:0];
  assign env_period    = {regs_q[AY_R_ENV_HI], regs_q[AY_R_ENV_LO]};
  assign env_shape     = regs_q[AY_R_ENV_SHAPE][3:0];

`ifdef AY_REGS_IO_EN
  assign io_a_out = regs_q[AY_R_IO_A];
  assign io_b_out = regs_q[AY_R_IO_B];
`else
  logic unused_io;
  assign unused_io = ^{io_a_in, io_b_in};
  assign io_a_out  = 8'h00;
  assign io_b_out  = 8'h00;
`endif

endmodule
